// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants for the CPU register file: default geometry and the hard-wired zero register.
package regfile_scoreboard_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned REG_ZERO   = 0;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Register-file bus: two read ports with busy flags, two write ports and the issue mark.
interface regfile_scoreboard_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4
);
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [WIDTH-1:0]  rd1;
  logic [WIDTH-1:0]  rd2;
  logic              busy1;
  logic              busy2;
  logic              wea;
  logic [ADDR_W-1:0] waa;
  logic [WIDTH-1:0]  wda;
  logic              web;
  logic [ADDR_W-1:0] wab;
  logic [WIDTH-1:0]  wdb;
  logic              mark_en;
  logic [ADDR_W-1:0] mark_addr;

  modport master (
    output ra1, ra2, wea, waa, wda, web, wab, wdb, mark_en, mark_addr,
    input  rd1, rd2, busy1, busy2
  );

  modport slave (
    input  ra1, ra2, wea, waa, wda, web, wab, wdb, mark_en, mark_addr,
    output rd1, rd2, busy1, busy2
  );
endinterface

// File: rtl/regfile_scoreboard_rf_scoreboard.sv
// Pending-write scoreboard: writes clear a register's pending bit, issue marks set it.
module rf_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wea,
  input  logic [ADDR_W-1:0] waa,
  input  logic              web,
  input  logic [ADDR_W-1:0] wab,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic              busy1,
  output logic              busy2
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  // Mark is applied last so a new producer wins over a retiring one.
  always_comb begin
    pending_d = pending_q;
    if (wea)     pending_d[waa]       = 1'b0;
    if (web)     pending_d[wab]       = 1'b0;
    if (mark_en) pending_d[mark_addr] = 1'b1;
    if (ZERO_REG != 0) pending_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign busy1 = pending_q[ra1];
  assign busy2 = pending_q[ra2];

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/two-write register file with optional registered bypassed reads and RAW scoreboard.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned ZERO_REG  = 1,
  parameter int unsigned SYNC_READ = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  bus
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             wea_ok;
  logic             web_ok;
  logic             ra1_zero;
  logic             ra2_zero;

  assign wea_ok   = bus.wea && !((ZERO_REG != 0) && (bus.waa == ADDR_W'(REG_ZERO)));
  assign web_ok   = bus.web && !((ZERO_REG != 0) && (bus.wab == ADDR_W'(REG_ZERO)));
  assign ra1_zero = (ZERO_REG != 0) && (bus.ra1 == ADDR_W'(REG_ZERO));
  assign ra2_zero = (ZERO_REG != 0) && (bus.ra2 == ADDR_W'(REG_ZERO));

  // Port B is applied after port A so it wins on an address collision.
  always_comb begin
    regs_d = regs_q;
    if (wea_ok) regs_d[bus.waa] = bus.wda;
    if (web_ok) regs_d[bus.wab] = bus.wdb;
  end

  always_ff @(posedge clk) begin
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  if (SYNC_READ != 0) begin : g_sync_read
    logic [WIDTH-1:0] rd1_q;
    logic [WIDTH-1:0] rd2_q;
    logic [WIDTH-1:0] rd1_d;
    logic [WIDTH-1:0] rd2_d;

    // Reading the post-write image gives write-through bypass for free.
    always_comb begin
      rd1_d = ra1_zero ? '0 : regs_d[bus.ra1];
      rd2_d = ra2_zero ? '0 : regs_d[bus.ra2];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rd1_q <= '0;
        rd2_q <= '0;
      end else begin
        rd1_q <= rd1_d;
        rd2_q <= rd2_d;
      end
    end

    assign bus.rd1 = rd1_q;
    assign bus.rd2 = rd2_q;
  end else begin : g_comb_read
    assign bus.rd1 = ra1_zero ? '0 : regs_q[bus.ra1];
    assign bus.rd2 = ra2_zero ? '0 : regs_q[bus.ra2];
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .wea       (bus.wea),
    .waa       (bus.waa),
    .web       (bus.web),
    .wab       (bus.wab),
    .mark_en   (bus.mark_en),
    .mark_addr (bus.mark_addr),
    .ra1       (bus.ra1),
    .ra2       (bus.ra2),
    .busy1     (bus.busy1),
    .busy2     (bus.busy2)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: default, ZERO_REG=0 and SYNC_READ=0 instances driven by one stimulus stream.
module tb_regfile_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       wea, web, mark_en;
  logic [3:0] waa, wab, mark_addr, ra1, ra2;
  logic [7:0] wda, wdb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_scoreboard_if #(.WIDTH(8), .ADDR_W(4)) if_def ();
  regfile_scoreboard_if #(.WIDTH(8), .ADDR_W(4)) if_z0  ();
  regfile_scoreboard_if #(.WIDTH(8), .ADDR_W(4)) if_as  ();

  assign {if_def.ra1, if_def.ra2, if_def.wea, if_def.waa, if_def.wda, if_def.web, if_def.wab, if_def.wdb, if_def.mark_en, if_def.mark_addr} =
         {ra1, ra2, wea, waa, wda, web, wab, wdb, mark_en, mark_addr};
  assign {if_z0.ra1, if_z0.ra2, if_z0.wea, if_z0.waa, if_z0.wda, if_z0.web, if_z0.wab, if_z0.wdb, if_z0.mark_en, if_z0.mark_addr} =
         {ra1, ra2, wea, waa, wda, web, wab, wdb, mark_en, mark_addr};
  assign {if_as.ra1, if_as.ra2, if_as.wea, if_as.waa, if_as.wda, if_as.web, if_as.wab, if_as.wdb, if_as.mark_en, if_as.mark_addr} =
         {ra1, ra2, wea, waa, wda, web, wab, wdb, mark_en, mark_addr};

  regfile_scoreboard #(.WIDTH(8), .ADDR_W(4), .ZERO_REG(1), .SYNC_READ(1))
    u_def (.clk(clk), .reset(reset), .bus(if_def));
  regfile_scoreboard #(.WIDTH(8), .ADDR_W(4), .ZERO_REG(0), .SYNC_READ(1))
    u_z0  (.clk(clk), .reset(reset), .bus(if_z0));
  regfile_scoreboard #(.WIDTH(8), .ADDR_W(4), .ZERO_REG(1), .SYNC_READ(0))
    u_as  (.clk(clk), .reset(reset), .bus(if_as));

  typedef struct {
    logic       wea;  logic [3:0] waa; logic [7:0] wda;
    logic       web;  logic [3:0] wab; logic [7:0] wdb;
    logic       mk;   logic [3:0] ma;
    logic [3:0] ra1;  logic [3:0] ra2;
    logic [7:0] rd1;  logic [7:0] rd2;
    logic       b1;   logic       b2;
    logic [7:0] z_rd1; logic      z_b1;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wea = 1'b0; waa = '0; wda = '0;
    web = 1'b0; wab = '0; wdb = '0;
    mark_en = 1'b0; mark_addr = '0;
  endtask

  initial begin
    // wea waa wda    web wab wdb    mk ma  ra1 ra2  rd1    rd2    b1 b2  z_rd1  z_b1
    vecs[0] = '{1, 3, 8'hA5, 0, 0, 8'h00, 0, 0, 3, 0, 8'hA5, 8'h00, 0, 0, 8'hA5, 0};
    vecs[1] = '{1, 5, 8'h11, 1, 5, 8'h22, 0, 0, 5, 3, 8'h22, 8'hA5, 0, 0, 8'h22, 0};
    vecs[2] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 5, 5, 8'h22, 8'h22, 0, 0, 8'h22, 0};
    vecs[3] = '{1, 0, 8'hFF, 0, 0, 8'h00, 1, 0, 0, 3, 8'h00, 8'hA5, 0, 0, 8'hFF, 1};
    vecs[4] = '{0, 0, 8'h00, 0, 0, 8'h00, 1, 7, 3, 7, 8'hA5, 8'h00, 0, 1, 8'hA5, 0};
    vecs[5] = '{0, 0, 8'h00, 1, 7, 8'h3C, 0, 0, 7, 7, 8'h3C, 8'h3C, 0, 0, 8'h3C, 0};
    vecs[6] = '{1, 7, 8'h44, 0, 0, 8'h00, 1, 7, 7, 7, 8'h44, 8'h44, 1, 1, 8'h44, 1};
    vecs[7] = '{1, 9, 8'h01, 1, 9, 8'h9A, 0, 0, 9, 7, 8'h9A, 8'h44, 0, 1, 8'h9A, 0};
    vecs[8] = '{0, 0, 8'h00, 0, 0, 8'h00, 1, 4, 4, 2, 8'h00, 8'h00, 1, 0, 8'h00, 1};
    vecs[9] = '{1, 4, 8'h12, 0, 0, 8'h00, 0, 0, 4, 9, 8'h12, 8'h9A, 0, 0, 8'h12, 0};

    idle();
    ra1 = '0; ra2 = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("reset rd1", if_def.rd1, 8'h00);
    chk("reset rd2", if_def.rd2, 8'h00);
    chk("reset busy1", {7'b0, if_def.busy1}, 8'h00);

    for (int i = 0; i < 10; i++) begin
      wea = vecs[i].wea; waa = vecs[i].waa; wda = vecs[i].wda;
      web = vecs[i].web; wab = vecs[i].wab; wdb = vecs[i].wdb;
      mark_en = vecs[i].mk; mark_addr = vecs[i].ma;
      ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
      tick();
      chk($sformatf("v%0d rd1", i), if_def.rd1, vecs[i].rd1);
      chk($sformatf("v%0d rd2", i), if_def.rd2, vecs[i].rd2);
      chk($sformatf("v%0d busy1", i), {7'b0, if_def.busy1}, {7'b0, vecs[i].b1});
      chk($sformatf("v%0d busy2", i), {7'b0, if_def.busy2}, {7'b0, vecs[i].b2});
      chk($sformatf("v%0d z0 rd1", i), if_z0.rd1, vecs[i].z_rd1);
      chk($sformatf("v%0d z0 busy1", i), {7'b0, if_z0.busy1}, {7'b0, vecs[i].z_b1});
      chk($sformatf("v%0d async rd1", i), if_as.rd1, vecs[i].rd1);
    end

    // Reset mid-sequence with a pending register and a colliding write/mark.
    idle();
    mark_en = 1'b1; mark_addr = 4'd4; ra1 = 4'd4; ra2 = 4'd7;
    tick();
    chk("pre-reset busy1", {7'b0, if_def.busy1}, 8'h01);
    chk("pre-reset busy2", {7'b0, if_def.busy2}, 8'h01);
    wea = 1'b1; waa = 4'd4; wda = 8'h33; mark_en = 1'b1; mark_addr = 4'd3;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    chk("rst rd1", if_def.rd1, 8'h00);
    chk("rst rd2", if_def.rd2, 8'h00);
    chk("rst busy1", {7'b0, if_def.busy1}, 8'h00);
    chk("rst busy2", {7'b0, if_def.busy2}, 8'h00);
    ra2 = 4'd3;
    tick();
    chk("rst write dropped", if_def.rd1, 8'h00);
    chk("rst mark dropped", {7'b0, if_def.busy2}, 8'h00);
    for (int a = 0; a < 16; a++) begin
      ra1 = 4'(a);
      #1;
      chk($sformatf("rst async r%0d", a), if_as.rd1, 8'h00);
      chk($sformatf("rst z0 busy r%0d", a), {7'b0, if_z0.busy1}, 8'h00);
    end

    // Busy tracks registered state only; mark beats a same-cycle write.
    idle();
    mark_en = 1'b1; mark_addr = 4'd7; ra2 = 4'd7; ra1 = 4'd0;
    tick();
    chk("mark7 busy2", {7'b0, if_def.busy2}, 8'h01);
    idle();
    web = 1'b1; wab = 4'd7; wdb = 8'h77;
    #3;
    chk("busy2 ignores same-cycle write", {7'b0, if_def.busy2}, 8'h01);
    tick();
    idle();
    chk("write7 busy2", {7'b0, if_def.busy2}, 8'h00);
    chk("write7 rd2", if_def.rd2, 8'h77);
    web = 1'b1; wab = 4'd7; wdb = 8'h78; mark_en = 1'b1; mark_addr = 4'd7;
    tick();
    idle();
    chk("mark+write busy2", {7'b0, if_def.busy2}, 8'h01);
    chk("mark+write rd2", if_def.rd2, 8'h78);
    tick();
    chk("mark+write busy2 held", {7'b0, if_def.busy2}, 8'h01);

    // Combinational reads see pre-edge contents until the write commits.
    idle();
    wea = 1'b1; waa = 4'd2; wda = 8'h5C; ra1 = 4'd2;
    #3;
    chk("async rd1 pre-edge", if_as.rd1, 8'h00);
    tick();
    idle();
    chk("async rd1 post-edge", if_as.rd1, 8'h5C);
    ra2 = 4'd7;
    #1;
    chk("async rd2 r7", if_as.rd2, 8'h78);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
